// File: rtl/fft_pkg.sv
// Shared defaults for the FFT output framing path.
package fft_pkg;

   localparam int unsigned FFT_OWIDTH  = 19;
   localparam int unsigned FFT_LGWIDTH = 4;
   localparam int unsigned FFT_N       = 1 << FFT_LGWIDTH;

   function automatic int unsigned fft_npts(input int unsigned lgwidth);
      return 1 << lgwidth;
   endfunction

endpackage

// File: rtl/fft_ostream_if.sv
// FFT result stream in, framed valid/ready stream out.
interface fft_ostream_if import fft_pkg::*; #(
   parameter int unsigned OWIDTH = FFT_OWIDTH
) ();

   logic                  i_ce;
   logic [2*OWIDTH-1:0]   i_result;
   logic                  i_sync;
   logic                  o_valid;
   logic                  i_ready;
   logic [2*OWIDTH-1:0]   o_data;
   logic                  o_last;
   logic                  o_overflow;

   modport master (
      output i_ce, i_result, i_sync, i_ready,
      input  o_valid, o_data, o_last, o_overflow
   );

   modport slave (
      input  i_ce, i_result, i_sync, i_ready,
      output o_valid, o_data, o_last, o_overflow
   );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-frame sample store: one write port, one registered read port with enable.
module fft_pingpong_ram import fft_pkg::*; #(
   parameter int unsigned Width = 2 * FFT_OWIDTH,
   parameter int unsigned AddrW = FFT_LGWIDTH + 1
) (
   input  logic             i_clk,
   input  logic             wr_en_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [Width-1:0] rd_data_o
);

   logic [Width-1:0] mem_q [2**AddrW];
   logic [Width-1:0] rd_data_q;

   // Read data holds when rd_en_i is low; the prefetch stage relies on that.
   always_ff @(posedge i_clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_ostream.sv
// Captures whole FFT frames into a ping-pong RAM and replays them on a valid/ready
// stream with an end-of-frame marker; frames arriving with no free buffer are dropped.
module fft_ostream import fft_pkg::*; #(
   parameter int unsigned OWIDTH  = FFT_OWIDTH,
   parameter int unsigned LGWIDTH = FFT_LGWIDTH
) (
   input logic          i_clk,
   input logic          i_reset,
   fft_ostream_if.slave bus
);

   localparam int unsigned        DW       = 2 * OWIDTH;
   localparam int unsigned        AW       = LGWIDTH + 1;
   localparam logic [LGWIDTH-1:0] LastAddr = LGWIDTH'(fft_npts(LGWIDTH) - 1);

   logic               synced_q, synced_d;
   logic               wr_buf_q, wr_buf_d;
   logic [LGWIDTH-1:0] wr_addr_q, wr_addr_d;
   logic               drop_q, drop_d;
   logic [1:0]         full_q, full_d;
   logic               ovf_q, ovf_d;
   logic               rd_buf_q, rd_buf_d;
   logic               iss_buf_q, iss_buf_d;
   logic [LGWIDTH-1:0] iss_addr_q, iss_addr_d;
   logic               pf_valid_q, pf_valid_d;
   logic               pf_last_q, pf_last_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic [DW-1:0]      out_data_q, out_data_d;

   logic               accept, frame_start, drop_now, wr_en;
   logic               rd_en, out_ready, last_xfer;
   logic [LGWIDTH-1:0] wa;
   logic [DW-1:0]      rd_data;

   // Write side: a sync restarts the frame at address 0 in the same buffer.
   always_comb begin
      accept      = bus.i_ce && (synced_q || bus.i_sync);
      wa          = bus.i_sync ? '0 : wr_addr_q;
      frame_start = accept && (wa == '0);
      drop_now    = frame_start ? full_q[wr_buf_q] : drop_q;
      wr_en       = accept && !drop_now;

      synced_d  = synced_q || accept;
      drop_d    = accept ? drop_now : drop_q;
      ovf_d     = ovf_q || (frame_start && full_q[wr_buf_q]);
      wr_addr_d = accept ? wa + 1'b1 : wr_addr_q;
      wr_buf_d  = wr_buf_q;
      full_d    = full_q;
      if (last_xfer) begin
         full_d[rd_buf_q] = 1'b0;
      end
      if (wr_en && (wa == LastAddr)) begin
         full_d[wr_buf_q] = 1'b1;
         wr_buf_d         = ~wr_buf_q;
      end
   end

   // Read side: issue pointer runs ahead of the drain pointer so the next frame's
   // prefetch overlaps the tail of the current one.
   always_comb begin
      out_ready = !out_valid_q || bus.i_ready;
      last_xfer = out_valid_q && bus.i_ready && out_last_q;
      rd_en     = full_q[iss_buf_q] && (!pf_valid_q || out_ready);

      iss_addr_d = iss_addr_q;
      iss_buf_d  = iss_buf_q;
      pf_valid_d = pf_valid_q;
      pf_last_d  = pf_last_q;
      if (rd_en) begin
         iss_addr_d = iss_addr_q + 1'b1;
         pf_valid_d = 1'b1;
         pf_last_d  = (iss_addr_q == LastAddr);
         if (iss_addr_q == LastAddr) begin
            iss_buf_d = ~iss_buf_q;
         end
      end else if (out_ready) begin
         pf_valid_d = 1'b0;
      end

      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (out_ready) begin
         out_valid_d = pf_valid_q;
         out_last_d  = pf_valid_q && pf_last_q;
         if (pf_valid_q) begin
            out_data_d = rd_data;
         end
      end
      rd_buf_d = last_xfer ? ~rd_buf_q : rd_buf_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         synced_q    <= 1'b0;
         wr_buf_q    <= 1'b0;
         wr_addr_q   <= '0;
         drop_q      <= 1'b0;
         full_q      <= '0;
         ovf_q       <= 1'b0;
         rd_buf_q    <= 1'b0;
         iss_buf_q   <= 1'b0;
         iss_addr_q  <= '0;
         pf_valid_q  <= 1'b0;
         pf_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         synced_q    <= synced_d;
         wr_buf_q    <= wr_buf_d;
         wr_addr_q   <= wr_addr_d;
         drop_q      <= drop_d;
         full_q      <= full_d;
         ovf_q       <= ovf_d;
         rd_buf_q    <= rd_buf_d;
         iss_buf_q   <= iss_buf_d;
         iss_addr_q  <= iss_addr_d;
         pf_valid_q  <= pf_valid_d;
         pf_last_q   <= pf_last_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   fft_pingpong_ram #(
      .Width (DW),
      .AddrW (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .wr_en_i   (wr_en),
      .wr_addr_i ({wr_buf_q, wa}),
      .wr_data_i (bus.i_result),
      .rd_en_i   (rd_en),
      .rd_addr_i ({iss_buf_q, iss_addr_q}),
      .rd_data_o (rd_data)
   );

   assign bus.o_valid    = out_valid_q;
   assign bus.o_data     = out_data_q;
   assign bus.o_last     = out_last_q;
   assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_fft_ostream.sv
// Bench for fft_ostream: frame-level scoreboard model plus directed and random stimulus.
module tb_fft_ostream;
   import fft_pkg::*;

   localparam int unsigned OW = FFT_OWIDTH;
   localparam int unsigned LG = FFT_LGWIDTH;
   localparam int          N  = FFT_N;
   localparam int unsigned DW = 2 * OW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_ostream_if #(.OWIDTH(OW)) bus ();

   fft_ostream #(
      .OWIDTH  (OW),
      .LGWIDTH (LG)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   int ready_mode = 0;
   int rdy_pct    = 50;
   int rc         = 0;

   // Behavioural model state: frames are whole objects; a frame is kept iff fewer
   // than two complete frames are still waiting to be drained at its start.
   logic [DW-1:0] exp_q[$];
   bit            expl_q[$];
   logic [DW-1:0] m_cur[$];
   int            m_frames = 0;
   int            m_addr   = 0;
   bit            m_synced = 0;
   bit            m_drop   = 0;
   bit            m_ovf    = 0;
   int            n_out    = 0;
   logic [DW-1:0] first_word = '0;
   bit            held_v   = 0;
   logic [DW-1:0] held_d   = '0;
   bit            held_l   = 0;

   function automatic logic [DW-1:0] mk(input int tag, input int k);
      logic [OW-1:0] re;
      logic [OW-1:0] im;
      re = OW'(tag * 16 + k);
      im = OW'(tag);
      return {re, im};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic put(input bit ce, input bit sync, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      bus.i_ce     = ce;
      bus.i_sync   = sync;
      bus.i_result = d;
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.i_ce     = 1'b0;
      bus.i_sync   = 1'b0;
      bus.i_result = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_frame(input int tag, input int gap_pct);
      for (int k = 0; k < N; k++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) put(1'b0, 1'b0, '0);
         put(1'b1, k == 0, mk(tag, k));
      end
      put(1'b0, 1'b0, '0);
   endtask

   task automatic wait_out(input int n, input int bound);
      for (int i = 0; i < bound && n_out < n; i++) @(posedge clk);
   endtask

   // Consumer ready pattern
   initial begin
      bus.i_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rc++;
         case (ready_mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = 1'b0;
            2:       bus.i_ready = (rc % 4 == 0) || (rc % 4 == 3);
            default: bus.i_ready = ($urandom_range(0, 99) < rdy_pct);
         endcase
      end
   end

   // Monitor: at each negedge, inputs and outputs are those the next posedge consumes.
   initial begin
      logic [DW-1:0] ed;
      bit            el;
      bit            xfer;
      forever begin
         @(negedge clk);
         check("overflow", 64'(bus.o_overflow), 64'(m_ovf));
         if (!bus.o_valid) check("last_without_valid", 64'(bus.o_last), 64'(0));
         if (held_v) begin
            check("stall_valid", 64'(bus.o_valid), 64'(1));
            check("stall_data", 64'(bus.o_data), 64'(held_d));
            check("stall_last", 64'(bus.o_last), 64'(held_l));
         end
         if (rst) begin
            exp_q.delete();
            expl_q.delete();
            m_cur.delete();
            m_frames = 0;
            m_addr   = 0;
            m_synced = 0;
            m_drop   = 0;
            m_ovf    = 0;
            n_out    = 0;
            held_v   = 0;
            continue;
         end
         held_v = bus.o_valid && !bus.i_ready;
         held_d = bus.o_data;
         held_l = bus.o_last;
         xfer   = bus.o_valid && bus.i_ready;

         if (bus.i_ce && (m_synced || bus.i_sync)) begin
            if (bus.i_sync) begin
               m_addr = 0;
               m_cur.delete();
            end
            if (m_addr == 0) begin
               m_drop = (m_frames == 2);
               if (m_drop) m_ovf = 1;
            end
            m_synced = 1;
            if (!m_drop) m_cur.push_back(bus.i_result);
            if (m_addr == N - 1) begin
               if (!m_drop) begin
                  for (int i = 0; i < N; i++) begin
                     exp_q.push_back(m_cur[i]);
                     expl_q.push_back(i == N - 1);
                  end
                  m_frames++;
               end
               m_cur.delete();
               m_addr = 0;
            end else begin
               m_addr++;
            end
         end

         if (xfer) begin
            n_out++;
            if (n_out == 1) first_word = bus.o_data;
            check("word_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               ed = exp_q.pop_front();
               el = expl_q.pop_front();
               check("data", 64'(bus.o_data), 64'(ed));
               check("last", 64'(bus.o_last), 64'(el));
               if (el) m_frames--;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   typedef struct {
      int            tag;
      int            pre;
      int            nframes;
      int            rmode;
      int            gap;
      int            exp_words;
      logic [DW-1:0] exp_first;
      bit            exp_ovf;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int k;
      bus.i_ce     = 1'b0;
      bus.i_sync   = 1'b0;
      bus.i_result = '0;

      vecs[0] = '{1, 0, 1, 0, 0,  16, mk(1, 0), 1'b0};
      vecs[1] = '{2, 5, 1, 0, 0,  16, mk(2, 0), 1'b0};
      vecs[2] = '{3, 0, 1, 2, 0,  16, mk(3, 0), 1'b0};
      vecs[3] = '{4, 3, 1, 3, 30, 16, mk(4, 0), 1'b0};
      vecs[4] = '{5, 0, 2, 2, 10, 32, mk(5, 0), 1'b0};

      // Basic frame with reset state and exact first-word latency
      ready_mode = 0;
      do_reset();
      check("reset_valid", 64'(bus.o_valid), 64'(0));
      check("reset_last", 64'(bus.o_last), 64'(0));
      check("reset_data", 64'(bus.o_data), 64'(0));
      check("reset_ovf", 64'(bus.o_overflow), 64'(0));
      send_frame(0, 0);
      check("lat_e0_valid", 64'(bus.o_valid), 64'(0));
      put(1'b0, 1'b0, '0);
      check("lat_e1_valid", 64'(bus.o_valid), 64'(0));
      put(1'b0, 1'b0, '0);
      check("lat_e2_valid", 64'(bus.o_valid), 64'(1));
      check("lat_e2_data", 64'(bus.o_data), 64'(mk(0, 0)));
      check("lat_e2_last", 64'(bus.o_last), 64'(0));
      wait_out(16, 100);
      idle(4);
      check("basic_words", 64'(n_out), 64'(16));

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         ready_mode = vecs[v].rmode;
         rdy_pct    = 50;
         do_reset();
         for (int i = 0; i < vecs[v].pre; i++) put(1'b1, 1'b0, mk(99, i));
         for (int f = 0; f < vecs[v].nframes; f++) send_frame(vecs[v].tag + f, vecs[v].gap);
         wait_out(vecs[v].exp_words, 600);
         idle(5);
         check($sformatf("vec%0d_words", v), 64'(n_out), 64'(vecs[v].exp_words));
         check($sformatf("vec%0d_first", v), 64'(first_word), 64'(vecs[v].exp_first));
         check($sformatf("vec%0d_ovf", v), 64'(bus.o_overflow), 64'(vecs[v].exp_ovf));
      end

      // Overflow: three frames with the consumer stalled
      ready_mode = 1;
      do_reset();
      send_frame(10, 0);
      send_frame(11, 0);
      check("ovf_before_c", 64'(bus.o_overflow), 64'(0));
      put(1'b1, 1'b1, mk(12, 0));
      put(1'b1, 1'b0, mk(12, 1));
      check("ovf_at_c", 64'(bus.o_overflow), 64'(1));
      for (int i = 2; i < N; i++) put(1'b1, 1'b0, mk(12, i));
      idle(3);
      ready_mode = 0;
      wait_out(32, 200);
      idle(10);
      check("ovf_words", 64'(n_out), 64'(32));
      check("ovf_first", 64'(first_word), 64'(mk(10, 0)));
      check("ovf_sticky", 64'(bus.o_overflow), 64'(1));

      // Mid-frame resync at sample 7
      ready_mode = 0;
      do_reset();
      for (int i = 0; i < 7; i++) put(1'b1, i == 0, mk(20, i));
      send_frame(21, 0);
      wait_out(16, 100);
      idle(5);
      check("resync_words", 64'(n_out), 64'(16));
      check("resync_first", 64'(first_word), 64'(mk(21, 0)));
      check("resync_ovf", 64'(bus.o_overflow), 64'(0));

      // Reset while word 9 is presented
      ready_mode = 0;
      do_reset();
      send_frame(22, 0);
      wait_out(9, 100);
      #1;
      check("pre_reset_valid", 64'(bus.o_valid), 64'(1));
      check("pre_reset_data", 64'(bus.o_data), 64'(mk(22, 9)));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", 64'(bus.o_valid), 64'(0));
      check("rst_last", 64'(bus.o_last), 64'(0));
      check("rst_ovf", 64'(bus.o_overflow), 64'(0));
      for (int i = 0; i < 4; i++) put(1'b1, 1'b0, mk(23, i));
      idle(20);
      check("rst_no_output", 64'(n_out), 64'(0));
      send_frame(24, 0);
      wait_out(16, 100);
      idle(4);
      check("rst_words", 64'(n_out), 64'(16));
      check("rst_first", 64'(first_word), 64'(mk(24, 0)));

      // Random stimulus against the model
      ready_mode = 3;
      do_reset();
      k = $urandom_range(0, N - 1);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 200 == 0) rdy_pct = $urandom_range(5, 100);
         if ($urandom_range(0, 99) < 70) begin
            if ($urandom_range(0, 99) < 2) k = 0;
            put(1'b1, k == 0, DW'({$urandom(), $urandom()}));
            k = (k + 1) % N;
         end else begin
            put(1'b0, 1'b0, '0);
         end
      end
      put(1'b0, 1'b0, '0);
      ready_mode = 0;
      idle(100);
      check("rand_drained", 64'(exp_q.size()), 64'(0));
      check("rand_frames", 64'(m_frames), 64'(0));
      check("rand_idle_valid", 64'(bus.o_valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
